cpu_output_uart: RTL and testbench
==================================

Name: cpu_output_uart

Overview:
Downstream consumer of the CPU output port. Captures each word written by an OUT instruction into a small FIFO, then serialises it on a single TX pin as two 8N1 UART frames (low byte first). This decouples the CPU's single-register output port from a slow serial link, so back-to-back OUT instructions are not lost while the FIFO has room.

Parameters:
DataWidth, 16, width of the CPU output word; must be 16 (two bytes per word).
FifoAddrBits, 2, log2 of FIFO depth (default depth 4 words).
ClksPerBit, 16, Clk cycles per UART bit; must be >= 2.

Ports:
Clk  input  1  system clock; all state changes on the rising edge.
Reset  input  1  asynchronous, active-low reset.
Out_Ld  input  1  CPU output-register load strobe (Output_Ld).
OutReg  input  DataWidth  CPU output register value; valid the cycle after Out_Ld.
Tx  output  1  UART serial out, idle high.
Busy  output  1  high while a frame is in progress or the FIFO is non-empty.
Full  output  1  FIFO holds 2^FifoAddrBits words.
Empty  output  1  FIFO holds 0 words.
Overflow  output  1  sticky; set when a capture is dropped.

Behaviour:
- Reset (Reset=0, asynchronous): Tx=1, Busy=0, Full=0, Empty=1, Overflow=0. FIFO pointers/count=0, FSM=IDLE, all delay flops=0. Reset mid-frame aborts the frame immediately; Tx returns to 1 with no glitch to 0.
- Capture: ld_d <= Out_Ld; ld_dd <= ld_d. Push request = ld_d & ~ld_dd (one push per Out_Ld assertion, sampled the cycle OutReg is updated). Data pushed = OutReg in that cycle.
- FIFO: depth 2^FifoAddrBits, circular, read/write pointers wrap modulo depth, count register of FifoAddrBits+1 bits. Full = (count == depth), Empty = (count == 0), both registered from count.
- Push while Full with no pop in the same cycle: word dropped, Overflow <= 1 (held until reset). Push while Full with a simultaneous pop: accepted, count unchanged.
- Pop occurs only in FSM IDLE when !Empty: the head word loads into a 16-bit hold register; byte_sel=0.
- FSM states, with bit counter bit_cnt (0..7) and baud counter baud_cnt (0..ClksPerBit-1):
  IDLE: Tx=1. If !Empty, pop and go to START.
  START: Tx=0 for ClksPerBit cycles, then go to DATA with bit_cnt=0.
  DATA: Tx = selected byte[bit_cnt], LSB first, each bit held ClksPerBit cycles. After bit 7, go to STOP.
  STOP: Tx=1 for ClksPerBit cycles. Then, if byte_sel==0: byte_sel<=1 and go to START (high byte, no idle gap). Else go to IDLE.
- Selected byte: byte_sel=0 gives hold[7:0]; byte_sel=1 gives hold[15:8].
- Tx is driven from a flop (registered, glitch-free). The start bit appears on Tx one cycle after the pop.
- Word time = 20*ClksPerBit cycles. Minimum latency from the push cycle to the Tx falling edge is 2 cycles when the FIFO is empty and the FSM is IDLE.
- Busy = (state != IDLE) | !Empty.
- Out_Ld held high for multiple cycles produces exactly one push.

Test Plan:
- Reset then idle 100 cycles -> Tx=1, Empty=1, Busy=0, Overflow=0 throughout.
- ClksPerBit=4, single Out_Ld pulse with OutReg=16'hA55A -> Tx bit sequence 0,0,1,0,1,1,0,1,0,1 then 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (80 cycles total); then Busy=0.
- Four Out_Ld pulses 3 cycles apart with 16'h0001, 16'h0002, 16'h0003, 16'h0004 -> all four words serialised in order; Full never asserted (first word popped before the fourth push); Overflow=0.
- Six pushes (16'h1111 through 16'h6666) while the first frame is active, depth 4 -> first word is popped, next four fill the FIFO (Full=1), sixth push sets Overflow=1; output sequence is 1111, 2222, 3333, 4444, 5555 and 6666 is absent.
- Out_Ld held high for 10 cycles with OutReg=16'h00FF -> exactly one word transmitted.
- Assert Reset during DATA of 16'hFFFF -> Tx=1 in the same cycle, FIFO empty; a new push afterwards transmits correctly.

Source files
------------

// File: rtl/cpu_output_uart_if.sv
// CPU output-port bundle: OUT-instruction load strobe and word towards the UART,
// serial line and FIFO status back, plus the serialiser state for observation.
interface cpu_output_uart_if #(
    parameter int DataWidth = 16
);
    logic                 Out_Ld;
    logic [DataWidth-1:0] OutReg;
    logic                 Tx;
    logic                 Busy;
    logic                 Full;
    logic                 Empty;
    logic                 Overflow;
    logic [1:0]           dbg_state;

    // No valid/ready pair: Out_Ld is a fire-and-forget strobe, OutReg is valid the
    // cycle after it rises, and a word arriving while the FIFO is full is dropped
    // and recorded in the sticky Overflow flag.
    modport master (
        output Out_Ld, OutReg,
        input  Tx, Busy, Full, Empty, Overflow, dbg_state
    );

    modport slave (
        input  Out_Ld, OutReg,
        output Tx, Busy, Full, Empty, Overflow, dbg_state
    );
endinterface

// File: rtl/cpu_output_uart.sv
// Buffers CPU OUT words in a small FIFO and sends each one as two 8N1 UART frames,
// low byte first, on a registered TX pin.
module cpu_output_uart #(
    parameter int DataWidth    = 16,
    parameter int FifoAddrBits = 2,
    parameter int ClksPerBit   = 16
) (
    input logic              Clk,
    input logic              Reset,
    cpu_output_uart_if.slave bus
);

    localparam int Depth  = 1 << FifoAddrBits;
    localparam int CountW = FifoAddrBits + 1;
    localparam int BaudW  = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    state_e                  state_q;
    logic [BaudW-1:0]        baud_q;
    logic [2:0]              bit_cnt_q;
    logic                    byte_sel_q;
    logic [DataWidth-1:0]    hold_q;
    logic                    tx_q;

    logic                    ld_d_q, ld_d_d;
    logic                    ld_dd_q, ld_dd_d;
    logic [FifoAddrBits-1:0] wr_ptr_q, wr_ptr_d;
    logic [FifoAddrBits-1:0] rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]       count_q, count_d;
    logic                    full_q, full_d;
    logic                    empty_q, empty_d;
    logic                    overflow_q, overflow_d;
    logic [DataWidth-1:0]    mem_q [Depth];

    logic                    push, pop, push_ok, baud_last;
    logic [7:0]              sel_byte;

    // OutReg only holds the new word one cycle after the strobe, so push on the
    // delayed rising edge of Out_Ld.
    assign push      = ld_d_q & ~ld_dd_q;
    assign pop       = (state_q == S_IDLE) & ~empty_q;
    assign push_ok   = push & (~full_q | pop);
    assign baud_last = (baud_q == BaudW'(ClksPerBit - 1));
    assign sel_byte  = byte_sel_q ? hold_q[15:8] : hold_q[7:0];

    always_comb begin
        ld_d_d     = bus.Out_Ld;
        ld_dd_d    = ld_d_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push & full_q & ~pop);
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CountW'(Depth));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ld_d_q     <= 1'b0;
            ld_dd_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            ld_d_q     <= ld_d_d;
            ld_dd_q    <= ld_dd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: count/pointers decide which entries are meaningful.
    always_ff @(posedge Clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= bus.OutReg;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            byte_sel_q <= 1'b0;
            hold_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        hold_q     <= mem_q[rd_ptr_q];
                        byte_sel_q <= 1'b0;
                        baud_q     <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= sel_byte[0];
                        state_q   <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= sel_byte[bit_cnt_q + 3'd1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        // High byte follows immediately, without passing through IDLE.
                        if (!byte_sel_q) begin
                            byte_sel_q <= 1'b1;
                            tx_q       <= 1'b0;
                            state_q    <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Tx        = tx_q;
    assign bus.Busy      = (state_q != S_IDLE) | ~empty_q;
    assign bus.Full      = full_q;
    assign bus.Empty     = empty_q;
    assign bus.Overflow  = overflow_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cpu_output_uart.sv
// Bench for cpu_output_uart: table of single-word frames with hand-derived TX bit
// patterns, plus sequences for FIFO fill, overflow and mid-frame reset.
module tb_cpu_output_uart;

    localparam int CPB = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cpu_output_uart_if #(.DataWidth(16)) bus ();

    cpu_output_uart #(
        .DataWidth   (16),
        .FifoAddrBits(2),
        .ClksPerBit  (CPB)
    ) dut (
        .Clk  (clk),
        .Reset(rst_n),
        .bus  (bus)
    );

    int tests  = 0;
    int failed = 0;

    logic [15:0] exp_q[$];
    logic [15:0] rx_q[$];

    typedef struct {
        logic [15:0] data;
        int          hold;
        logic [19:0] frame;  // TX bits in line order, first bit in the MSB
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line receiver: decodes 8N1 frames mid-bit and pairs bytes into words.
    bit         mon_en = 1'b0;
    bit         mon_active = 1'b0;
    bit         mon_hi = 1'b0;
    int         mon_cnt = 0;
    int         mon_k = 0;
    logic [7:0] mon_byte = '0;
    logic [7:0] mon_lo = '0;

    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            mon_active = 1'b0;
            mon_hi     = 1'b0;
        end else if (!mon_active) begin
            if (bus.Tx == 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt >= CPB / 2 && ((mon_cnt - CPB / 2) % CPB) == 0) begin
                mon_k = (mon_cnt - CPB / 2) / CPB;
                if (mon_k == 0) begin
                    check("start_bit", {31'd0, bus.Tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = bus.Tx;
                end else begin
                    check("stop_bit", {31'd0, bus.Tx}, 32'd1);
                    mon_active = 1'b0;
                    if (!mon_hi) begin
                        mon_lo = mon_byte;
                        mon_hi = 1'b1;
                    end else begin
                        rx_q.push_back({mon_byte, mon_lo});
                        mon_hi = 1'b0;
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input string tag);
        int          fall_t;
        int          nb;
        logic [19:0] got;
        logic [15:0] word;
        rx_q.delete();
        fall_t = -1;
        nb     = 0;
        got    = '0;
        @(negedge clk);
        bus.OutReg = v.data;
        bus.Out_Ld = 1'b1;
        for (int t = 1; t <= 110; t++) begin
            @(negedge clk);
            if (t == v.hold) bus.Out_Ld = 1'b0;
            if (fall_t < 0 && bus.Tx == 1'b0) fall_t = t;
            if (fall_t >= 0 && nb < 20 && (t - fall_t) >= CPB / 2 &&
                ((t - fall_t - CPB / 2) % CPB) == 0) begin
                got[19-nb] = bus.Tx;
                nb++;
            end
        end
        check({tag, "_latency"}, fall_t, 32'd3);
        check({tag, "_frame"}, {12'd0, got}, {12'd0, v.frame});
        check({tag, "_words"}, rx_q.size(), 32'd1);
        word = (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx;
        check({tag, "_word"}, {16'd0, word}, {16'd0, v.data});
        check({tag, "_busy"}, {31'd0, bus.Busy}, 32'd0);
        check({tag, "_empty"}, {31'd0, bus.Empty}, 32'd1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_tx", {31'd0, bus.Tx}, 32'd1);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_full", {31'd0, bus.Full}, 32'd0);
        check("rst_empty", {31'd0, bus.Empty}, 32'd1);
        check("rst_overflow", {31'd0, bus.Overflow}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rx_q.delete();
    endtask

    // Start a word, then pull reset while bit 1 of the low byte is on the line.
    task automatic reset_mid_data(input logic [15:0] data, input logic exp_tx, input string tag);
        @(negedge clk);
        bus.OutReg = data;
        bus.Out_Ld = 1'b1;
        @(negedge clk);
        bus.Out_Ld = 1'b0;
        repeat (11) @(negedge clk);
        check({tag, "_in_data"}, {30'd0, bus.dbg_state}, 32'd2);
        check({tag, "_tx_before"}, {31'd0, bus.Tx}, {31'd0, exp_tx});
        #1 rst_n = 1'b0;
        #1;
        check({tag, "_tx_at_reset"}, {31'd0, bus.Tx}, 32'd1);
        check({tag, "_empty_at_reset"}, {31'd0, bus.Empty}, 32'd1);
        check({tag, "_busy_at_reset"}, {31'd0, bus.Busy}, 32'd0);
        repeat (2) @(negedge clk);
        check({tag, "_tx_held"}, {31'd0, bus.Tx}, 32'd1);
        rst_n = 1'b1;
        rx_q.delete();
    endtask

    task automatic drain(input int budget, output bit full_seen, output bit ovf_seen);
        full_seen = 1'b0;
        ovf_seen  = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (bus.Full) full_seen = 1'b1;
            if (bus.Overflow) ovf_seen = 1'b1;
            if (rx_q.size() >= exp_q.size() && !bus.Busy) break;
        end
        repeat (100) @(negedge clk);
        if (bus.Overflow) ovf_seen = 1'b1;
    endtask

    task automatic compare_words(input string tag);
        int n;
        n = exp_q.size();
        check({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_word"}, {16'd0, (i < rx_q.size()) ? rx_q[i] : 16'hxxxx}, {16'd0, exp_q[i]});
        end
    endtask

    initial begin
        bit full_seen;
        bit ovf_seen;
        int idle_bad;

        vecs[0] = '{data: 16'hA55A, hold: 1,  frame: 20'h2D54B};
        vecs[1] = '{data: 16'h1234, hold: 1,  frame: 20'h16491};
        vecs[2] = '{data: 16'h00FF, hold: 10, frame: 20'h7FC01};
        vecs[3] = '{data: 16'hFFFF, hold: 3,  frame: 20'h7FDFF};
        vecs[4] = '{data: 16'h0000, hold: 1,  frame: 20'h00401};

        bus.Out_Ld = 1'b0;
        bus.OutReg = '0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        check("init_tx", {31'd0, bus.Tx}, 32'd1);
        check("init_busy", {31'd0, bus.Busy}, 32'd0);
        check("init_full", {31'd0, bus.Full}, 32'd0);
        check("init_empty", {31'd0, bus.Empty}, 32'd1);
        check("init_overflow", {31'd0, bus.Overflow}, 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        idle_bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.Tx !== 1'b1 || bus.Empty !== 1'b1 || bus.Busy !== 1'b0 || bus.Overflow !== 1'b0)
                idle_bad++;
        end
        check("idle_100", idle_bad, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Four words three cycles apart: the first is popped before the fourth lands.
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.OutReg = 16'(i + 1);
            bus.Out_Ld = 1'b1;
            exp_q.push_back(16'(i + 1));
            @(negedge clk);
            bus.Out_Ld = 1'b0;
            @(negedge clk);
        end
        drain(2000, full_seen, ovf_seen);
        compare_words("four");
        check("four_full_seen", {31'd0, full_seen}, 32'd0);
        check("four_overflow", {31'd0, ovf_seen}, 32'd0);

        // Six words two cycles apart: five fit (one popped, four buffered), the sixth drops.
        rx_q.delete();
        exp_q.delete();
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.OutReg = {4{4'(i)}};
            bus.Out_Ld = 1'b1;
            if (i <= 5) exp_q.push_back({4{4'(i)}});
            @(negedge clk);
            bus.Out_Ld = 1'b0;
        end
        drain(2000, full_seen, ovf_seen);
        compare_words("six");
        check("six_full_seen", {31'd0, full_seen}, 32'd1);
        check("six_overflow", {31'd0, ovf_seen}, 32'd1);
        check("six_overflow_sticky", {31'd0, bus.Overflow}, 32'd1);

        apply_reset();
        reset_mid_data(16'hFFFF, 1'b1, "abort_ffff");
        reset_mid_data(16'h0000, 1'b0, "abort_0000");
        repeat (5) @(negedge clk);
        run_vec(vecs[1], "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
